hanoi_solver: RTL and testbench

- Parametrised Tower of Hanoi engine, successor to the fixed 20-disc, 3-peg puzzle model.
- Generalises disc count, peg count and target peg.
- Adds reset, an illegal-move flag, a move counter, and an autonomous solver mode that emits the optimal move sequence.
- Used as a formal-verification and simulation benchmark. The environment drives moves manually or starts the solver and checks `done`.

---
 rtl/hanoi_solver_if.sv | 27 ++
 rtl/hanoi_solver.sv | 145 ++++++++++++++
 tb/tb_hanoi_solver.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/hanoi_solver_if.sv
// Request/status bundle for the Tower of Hanoi engine.
// The environment drives moves and starts the solver through master; the engine is the slave.
interface hanoi_solver_if #(
    parameter int NDISCS = 8,
    parameter int PEGW   = 2,
    parameter int CNTW   = 32
);
    logic                     move_valid;
    logic [PEGW-1:0]          from;
    logic [PEGW-1:0]          to;
    logic                     auto_start;
    logic                     busy;
    logic                     done;
    logic                     illegal;
    logic [CNTW-1:0]          move_count;
    logic [NDISCS*PEGW-1:0]   disc_peg;

    modport master (
        output move_valid, from, to, auto_start,
        input  busy, done, illegal, move_count, disc_peg
    );

    modport slave (
        input  move_valid, from, to, auto_start,
        output busy, done, illegal, move_count, disc_peg
    );
endinterface

// File: rtl/hanoi_solver.sv
// Parametrised Tower of Hanoi engine: manual moves with legality check, plus an
// autonomous iterative solver that emits the optimal move sequence on pegs 0..2.
module hanoi_solver #(
    parameter int NDISCS = 8,
    parameter int NPEGS  = 3,
    parameter int PEGW   = 2,
    parameter int TARGET = 1,
    parameter int CNTW   = 32
) (
    input  logic          clock,
    input  logic          reset,
    hanoi_solver_if.slave bus
);
    localparam int NSLOT = 1 << PEGW;
    localparam int TW    = $clog2(NDISCS + 1);
    // Direction disc 0 cycles through pegs 0..2 so the tower lands on TARGET.
    localparam int DSTEP = (NDISCS % 2 == 1) ? TARGET : 3 - TARGET;

    typedef enum logic [1:0] {IDLE, AUTO_SMALL, AUTO_OTHER} state_t;

    state_t              state, state_next;
    logic [PEGW-1:0]     pegs [NDISCS];
    logic [TW-1:0]       top  [NSLOT];
    logic [CNTW-1:0]     count;
    logic                illegal_q;

    logic                all_home;
    logic                rest_on_target;
    logic                legal;
    logic [PEGW-1:0]     small_dst;
    logic [PEGW-1:0]     peg_a, peg_b;

    logic                move_en;
    logic [TW-1:0]       move_disc;
    logic [PEGW-1:0]     move_dst;
    logic                illegal_next;

    // Board summary: top disc of every peg slot, plus whole-tower predicates.
    always_comb begin
        all_home       = 1'b1;
        rest_on_target = 1'b1;
        for (int i = 0; i < NDISCS; i++) begin
            if (pegs[i] != '0) all_home = 1'b0;
            if (i > 0 && pegs[i] != PEGW'(TARGET)) rest_on_target = 1'b0;
        end
        for (int p = 0; p < NSLOT; p++) begin
            top[p] = TW'(NDISCS);
            for (int i = NDISCS - 1; i >= 0; i--) begin
                if (pegs[i] == PEGW'(p)) top[p] = TW'(i);
            end
        end
    end

    assign legal = (int'(bus.from) < NPEGS) && (int'(bus.to) < NPEGS) &&
                   (bus.from != bus.to) &&
                   (top[bus.from] < TW'(NDISCS)) &&
                   (top[bus.from] < top[bus.to]);

    assign small_dst = PEGW'((int'(pegs[0]) + DSTEP) % 3);

    // The two solver pegs not holding disc 0.
    always_comb begin
        case (pegs[0])
            PEGW'(0): begin peg_a = PEGW'(1); peg_b = PEGW'(2); end
            PEGW'(1): begin peg_a = PEGW'(0); peg_b = PEGW'(2); end
            default:  begin peg_a = PEGW'(0); peg_b = PEGW'(1); end
        endcase
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_next   = state;
        move_en      = 1'b0;
        move_disc    = '0;
        move_dst     = '0;
        illegal_next = 1'b0;
        case (state)
            IDLE: begin
                if (bus.auto_start) begin
                    if (all_home) state_next   = AUTO_SMALL;
                    else          illegal_next = 1'b1;
                end else if (bus.move_valid) begin
                    if (legal) begin
                        move_en   = 1'b1;
                        move_disc = top[bus.from];
                        move_dst  = bus.to;
                    end else begin
                        illegal_next = 1'b1;
                    end
                end
            end
            AUTO_SMALL: begin
                move_en   = 1'b1;
                move_disc = '0;
                move_dst  = small_dst;
                // The tower completes only on the final move, which is always a disc-0 move.
                state_next = (small_dst == PEGW'(TARGET) && rest_on_target) ? IDLE : AUTO_OTHER;
            end
            AUTO_OTHER: begin
                move_en    = 1'b1;
                state_next = AUTO_SMALL;
                if (top[peg_a] < top[peg_b]) begin
                    move_disc = top[peg_a];
                    move_dst  = peg_b;
                end else begin
                    move_disc = top[peg_b];
                    move_dst  = peg_a;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: the disc array is architectural state, so it is reset element by element rather than left to power-up.
            for (int i = 0; i < NDISCS; i++) pegs[i] <= '0;
            count     <= '0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_next;
            if (move_en) begin
                for (int i = 0; i < NDISCS; i++) begin
                    if (move_disc == TW'(i)) pegs[i] <= move_dst;
                end
                if (count != '1) count <= count + CNTW'(1);
            end
        end
    end

    for (genvar g = 0; g < NDISCS; g++) begin : g_pack
        assign bus.disc_peg[g*PEGW +: PEGW] = pegs[g];
    end

    assign bus.busy       = (state != IDLE);
    assign bus.done       = rest_on_target && (pegs[0] == PEGW'(TARGET));
    assign bus.illegal    = illegal_q;
    assign bus.move_count = count;
endmodule

// File: tb/tb_hanoi_solver.sv
// Directed bench for hanoi_solver: a 3-disc engine targeting peg 1 and a
// 4-disc engine targeting peg 2, sharing clock and reset.
module tb_hanoi_solver;
    logic clock;
    logic reset;

    int vectors = 0;
    int errors  = 0;

    hanoi_solver_if #(.NDISCS(3), .PEGW(2), .CNTW(32)) bus3 ();
    hanoi_solver_if #(.NDISCS(4), .PEGW(2), .CNTW(32)) bus4 ();

    hanoi_solver #(.NDISCS(3), .NPEGS(3), .PEGW(2), .TARGET(1), .CNTW(32)) u3 (
        .clock (clock),
        .reset (reset),
        .bus   (bus3)
    );

    hanoi_solver #(.NDISCS(4), .NPEGS(3), .PEGW(2), .TARGET(2), .CNTW(32)) u4 (
        .clock (clock),
        .reset (reset),
        .bus   (bus4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One solver step on 4 discs: exactly one disc moved, it was on top of its
    // source, and no smaller disc already sat on its destination.
    function automatic bit step_ok(input logic [7:0] prev, input logic [7:0] cur);
        int changed = 0;
        int moved   = 0;
        for (int i = 0; i < 4; i++) begin
            if (prev[2*i +: 2] != cur[2*i +: 2]) begin
                changed++;
                moved = i;
            end
        end
        if (changed != 1) return 1'b0;
        for (int j = 0; j < moved; j++) begin
            if (prev[2*j +: 2] == prev[2*moved +: 2]) return 1'b0;
            if (prev[2*j +: 2] == cur[2*moved +: 2])  return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic idle_inputs();
        bus3.move_valid = 1'b0; bus3.auto_start = 1'b0; bus3.from = 2'd0; bus3.to = 2'd0;
        bus4.move_valid = 1'b0; bus4.auto_start = 1'b0; bus4.from = 2'd0; bus4.to = 2'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    logic [7:0] seq3 [1:7];
    logic [7:0] prev, cur;

    initial begin
        seq3[1] = 8'h01; seq3[2] = 8'h09; seq3[3] = 8'h0A; seq3[4] = 8'h1A;
        seq3[5] = 8'h18; seq3[6] = 8'h14; seq3[7] = 8'h15;

        idle_inputs();
        reset = 1'b1;
        #12;
        check("rst3_count",   bus3.move_count, 0);
        check("rst3_busy",    bus3.busy, 0);
        check("rst3_illegal", bus3.illegal, 0);
        check("rst3_done",    bus3.done, 0);
        check("rst3_pegs",    bus3.disc_peg, 0);
        check("rst4_pegs",    bus4.disc_peg, 0);
        check("rst4_done",    bus4.done, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // 3-disc autonomous solve toward peg 1.
        bus3.auto_start = 1'b1;
        @(negedge clock);
        bus3.auto_start = 1'b0;
        check("a_busy_start",  bus3.busy, 1);
        check("a_count_start", bus3.move_count, 0);
        for (int m = 1; m <= 7; m++) begin
            @(negedge clock);
            check($sformatf("a_pegs_%0d", m),  bus3.disc_peg, seq3[m]);
            check($sformatf("a_count_%0d", m), bus3.move_count, m);
            check($sformatf("a_busy_%0d", m),  bus3.busy, (m < 7) ? 1 : 0);
            check($sformatf("a_done_%0d", m),  bus3.done, (m == 7) ? 1 : 0);
        end

        // Manual move off the target drops done; moving back restores it.
        bus3.move_valid = 1'b1; bus3.from = 2'd1; bus3.to = 2'd0;
        @(negedge clock);
        bus3.from = 2'd0; bus3.to = 2'd1;
        check("f_done_off",  bus3.done, 0);
        check("f_count_off", bus3.move_count, 8);
        check("f_pegs_off",  bus3.disc_peg, 8'h14);
        @(negedge clock);
        bus3.move_valid = 1'b0;
        check("f_done_back",  bus3.done, 1);
        check("f_count_back", bus3.move_count, 9);

        // Manual legality on 3 discs.
        do_reset();
        bus3.move_valid = 1'b1; bus3.from = 2'd0; bus3.to = 2'd1;
        @(negedge clock);
        check("d_legal_count", bus3.move_count, 1);
        check("d_legal_pegs",  bus3.disc_peg, 8'h01);
        check("d_legal_ill",   bus3.illegal, 0);
        @(negedge clock);
        bus3.from = 2'd2; bus3.to = 2'd0;
        check("d_bigger_ill",   bus3.illegal, 1);
        check("d_bigger_count", bus3.move_count, 1);
        check("d_bigger_pegs",  bus3.disc_peg, 8'h01);
        @(negedge clock);
        bus3.from = 2'd1; bus3.to = 2'd1;
        check("d_empty_ill",   bus3.illegal, 1);
        check("d_empty_count", bus3.move_count, 1);
        @(negedge clock);
        bus3.from = 2'd3; bus3.to = 2'd0;
        check("d_same_ill",   bus3.illegal, 1);
        check("d_same_count", bus3.move_count, 1);
        @(negedge clock);
        bus3.move_valid = 1'b0;
        check("d_range_ill",   bus3.illegal, 1);
        check("d_range_count", bus3.move_count, 1);
        @(negedge clock);
        check("d_ill_drop", bus3.illegal, 0);

        // auto_start outside the initial configuration is rejected.
        bus3.auto_start = 1'b1;
        @(negedge clock);
        bus3.auto_start = 1'b0;
        check("e_ill",  bus3.illegal, 1);
        check("e_busy", bus3.busy, 0);
        @(negedge clock);
        check("e_ill_drop", bus3.illegal, 0);
        check("e_busy2",    bus3.busy, 0);
        check("e_pegs",     bus3.disc_peg, 8'h01);

        // 4-disc solve toward peg 2 with move_valid held high throughout.
        do_reset();
        bus4.auto_start = 1'b1;
        bus4.move_valid = 1'b1; bus4.from = 2'd0; bus4.to = 2'd1;
        @(negedge clock);
        bus4.auto_start = 1'b0;
        check("b_busy_start",  bus4.busy, 1);
        check("b_count_start", bus4.move_count, 0);
        prev = 8'h00;
        for (int m = 1; m <= 15; m++) begin
            @(negedge clock);
            cur = bus4.disc_peg;
            check($sformatf("b_step_%0d", m),  step_ok(prev, cur), 1);
            check($sformatf("b_ill_%0d", m),   bus4.illegal, 0);
            check($sformatf("b_count_%0d", m), bus4.move_count, m);
            check($sformatf("b_busy_%0d", m),  bus4.busy, (m < 15) ? 1 : 0);
            if (m == 1) check("b_first_move", cur, 8'h01);
            if (m == 8) check("b_mid_move",   cur, 8'h95);
            prev = cur;
        end
        bus4.move_valid = 1'b0;
        check("b_done",  bus4.done, 1);
        check("b_pegs",  bus4.disc_peg, 8'hAA);
        check("b_count", bus4.move_count, 15);

        // Asynchronous reset mid-solve, between clock edges.
        do_reset();
        bus4.auto_start = 1'b1;
        @(negedge clock);
        bus4.auto_start = 1'b0;
        for (int i = 0; i < 40 && bus4.move_count != 5; i++) @(negedge clock);
        check("c_reached_5", bus4.move_count, 5);
        #2;
        reset = 1'b1;
        #1;
        check("c_busy",  bus4.busy, 0);
        check("c_count", bus4.move_count, 0);
        check("c_pegs",  bus4.disc_peg, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("c_stays_idle",  bus4.busy, 0);
        check("c_stays_count", bus4.move_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
